// File: rtl/nios2_system_timer_scheduler.sv
// Round-robin scheduler sharing one interval timer (s1 port) between
// NUM_REQ hardware requesters; each grant runs N timer periods.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   req                 level request per requester
//   req_ticks           per-requester period count, slice i at [i*TICK_W +: TICK_W]
//   done                one-cycle completion pulse per requester
//   busy                high whenever the FSM is not idle
//   grant_id            index of the requester being served
//   tmr_address/chipselect/write_n/writedata
//                       Avalon-MM write master towards the timer
//   tmr_irq             timer timeout interrupt (level)
module nios2_system_timer_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TICK_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*TICK_W-1:0] req_ticks,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic [2:0]                tmr_address,
    output logic                      tmr_chipselect,
    output logic                      tmr_write_n,
    output logic [15:0]               tmr_writedata,
    input  logic                      tmr_irq
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW1   = IDX_W + 1;

    localparam logic [15:0] CTRL_START = 16'h0007;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_CLR,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDX_W-1:0]  gnt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  pick;
    logic              found;
    logic [IW1-1:0]    idx;
    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] ticks_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ticks
        assign ticks_arr[g] = req_ticks[g*TICK_W +: TICK_W];
    end

    // First set request at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + IW1'(k);
            if (idx >= IW1'(NUM_REQ)) begin
                idx = idx - IW1'(NUM_REQ);
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    state_nx = (ticks_arr[pick] == '0) ? S_DONE : S_START;
                end
            end
            S_START: state_nx = S_RUN;
            S_RUN: begin
                if (tmr_irq) begin
                    state_nx = S_CLR;
                end
            end
            // cnt==1 here means this timeout was the last one.
            S_CLR:   state_nx = (cnt == TICK_W'(1)) ? S_STOP : S_RUN;
            S_STOP:  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && found) begin
                gnt <= pick;
                cnt <= ticks_arr[pick];
            end
            if (state == S_CLR) begin
                cnt <= cnt - TICK_W'(1);
            end
            if (state == S_DONE) begin
                rr_ptr <= (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + IDX_W'(1);
            end
        end
    end

    // Bus and status outputs depend on the state register only.
    always_comb begin
        busy           = (state != S_IDLE);
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        unique case (1'b1)
            (state == S_START): begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = CTRL_START;
            end
            (state == S_CLR): begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd0;
                tmr_writedata  = 16'h0000;
            end
            (state == S_STOP): begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = CTRL_STOP;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        done = '0;
        if (state == S_DONE) begin
            done[gnt] = 1'b1;
        end
    end

    assign grant_id = 3'(gnt);

endmodule

// File: tb/tb_nios2_system_timer_scheduler.sv
// Directed bench for nios2_system_timer_scheduler with a shortened
// interval-timer model and write/done scoreboards.
module tb_nios2_system_timer_scheduler;

    localparam int PERIOD = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_ticks;
    logic [3:0]  done;
    logic        busy;
    logic [2:0]  grant_id;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    nios2_system_timer_scheduler #(
        .NUM_REQ(4),
        .TICK_W (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_ticks     (req_ticks),
        .done          (done),
        .busy          (busy),
        .grant_id      (grant_id),
        .tmr_address   (tmr_address),
        .tmr_chipselect(tmr_chipselect),
        .tmr_write_n   (tmr_write_n),
        .tmr_writedata (tmr_writedata),
        .tmr_irq       (tmr_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  rise_cyc = 0;
    int  stop_cyc = 0;
    int  clr_count = 0;
    bit  stop_pend = 0;
    logic irq_q = 1'b0;
    wr_t e;
    int  d1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Timer model: control START reloads the period, STOP halts,
    // status write clears irq.
    logic        t_run;
    int          t_cnt;
    wire         wr_en = tmr_chipselect && !tmr_write_n;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            t_run   <= 1'b0;
            t_cnt   <= 0;
            tmr_irq <= 1'b0;
        end else begin
            if (wr_en && tmr_address == 3'd1 && tmr_writedata[3]) begin
                t_run <= 1'b0;
            end else if (wr_en && tmr_address == 3'd1 && tmr_writedata[2]) begin
                t_run <= 1'b1;
                t_cnt <= PERIOD - 1;
            end else if (t_run) begin
                if (t_cnt == 0) begin
                    t_cnt   <= PERIOD - 1;
                    tmr_irq <= 1'b1;
                end else begin
                    t_cnt <= t_cnt - 1;
                end
            end
            if (wr_en && tmr_address == 3'd0) begin
                tmr_irq <= 1'b0;
            end
        end
    end

    // Output monitor: pops expected writes and done pulses.
    always @(negedge clk) begin
        if (tmr_irq && !irq_q) rise_cyc = cyc;
        irq_q = tmr_irq;
        if (wr_en) begin
            check("wq_nonempty", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                check("wr_addr", 32'(tmr_address), 32'(e.a));
                check("wr_data", 32'(tmr_writedata), 32'(e.d));
            end
            if (tmr_address == 3'd0) begin
                clr_count++;
                check("clr_after_irq", 32'(cyc), 32'(rise_cyc + 1));
            end
            if (tmr_address == 3'd1 && tmr_writedata == 16'h0008) begin
                stop_pend = 1;
                stop_cyc  = cyc;
            end
        end
        if (done != 4'd0) begin
            check("dq_nonempty", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) begin
                d1 = dq.pop_front();
                check("done_vec", 32'(done), 32'd1 << d1);
            end
            if (stop_pend) begin
                check("done_after_stop", 32'(cyc), 32'(stop_cyc + 1));
                stop_pend = 0;
            end
        end
    end

    task automatic push_seq(input int id, input int ticks);
        if (ticks > 0) begin
            wq.push_back('{a: 3'd1, d: 16'h0007});
            for (int i = 0; i < ticks; i++) begin
                wq.push_back('{a: 3'd0, d: 16'h0000});
            end
            wq.push_back('{a: 3'd1, d: 16'h0008});
        end
        dq.push_back(id);
    endtask

    task automatic wait_done(output logic [3:0] d);
        int n = 0;
        d = 4'd0;
        while (n < 3000) begin
            @(negedge clk);
            if (done != 4'd0) begin
                d = done;
                break;
            end
            n++;
        end
        check("wait_done_bound", 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_clr(input int target);
        int n = 0;
        while (clr_count < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_clr_bound", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        logic [3:0] d;
        int base;
        reset = 1'b1;
        req   = 4'hF;
        req_ticks = {16'd1, 16'd1, 16'd1, 16'd1};
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_cs", 32'(tmr_chipselect), 32'd0);
        check("rst_wn", 32'(tmr_write_n), 32'd1);
        check("rst_addr", 32'(tmr_address), 32'd0);
        check("rst_wdata", 32'(tmr_writedata), 32'd0);

        // All four requesting: served 0,1,2,3.
        for (int i = 0; i < 4; i++) push_seq(i, 1);
        reset = 1'b0;
        @(negedge clk);
        check("first_gid", 32'(grant_id), 32'd0);
        check("first_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_done(d);
            check("rr_order", 32'(d), 32'd1 << i);
            req = req & ~d;
        end

        // req=1001 with rr_ptr back at 0: 0 then 3.
        push_seq(0, 1);
        push_seq(3, 1);
        req = 4'b1001;
        wait_done(d);
        check("rr9_first", 32'(d), 32'h1);
        req = req & ~d;
        wait_done(d);
        check("rr9_second", 32'(d), 32'h8);
        req = req & ~d;

        // Two timeouts for requester 0.
        req_ticks[15:0] = 16'd2;
        push_seq(0, 2);
        req = 4'b0001;
        wait_done(d);
        check("t2_done", 32'(d), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        check("t2_busy_fall", 32'(busy), 32'd0);

        // Zero ticks: done next cycle, no bus traffic.
        req_ticks[47:32] = 16'd0;
        push_seq(2, 0);
        req = 4'b0100;
        @(negedge clk);
        check("t0_done", 32'(done), 32'h4);
        check("t0_gid", 32'(grant_id), 32'd2);
        check("t0_cs", 32'(tmr_chipselect), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        check("t0_busy_fall", 32'(busy), 32'd0);

        // Reset while waiting in RUN after two timeouts.
        req_ticks[31:16] = 16'd5;
        wq.push_back('{a: 3'd1, d: 16'h0007});
        wq.push_back('{a: 3'd0, d: 16'h0000});
        wq.push_back('{a: 3'd0, d: 16'h0000});
        base = clr_count;
        req = 4'b0010;
        wait_clr(base + 2);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wq", 32'(wq.size()), 32'd0);
        repeat (40) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Fresh request, req dropped right after grant, ticks changed late.
        req_ticks[31:16] = 16'd1;
        push_seq(1, 1);
        req = 4'b0010;
        @(negedge clk);
        check("drop_gid", 32'(grant_id), 32'd1);
        check("drop_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        req_ticks[31:16] = 16'd9;
        wait_done(d);
        check("drop_done", 32'(d), 32'h2);
        repeat (60) @(negedge clk);
        check("drop_idle", 32'(busy), 32'd0);

        check("end_wq", 32'(wq.size()), 32'd0);
        check("end_dq", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
